// File: rtl/uart_bridge_pkg.sv
// Shared types and defaults for the UART APB transmit bridge.
package uart_bridge_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } apb_state_e;

    localparam logic [31:0] DEFAULT_TX_ADDR = 32'h1000_0000;

endpackage

// File: rtl/byte_fifo.sv
// Byte-wide FIFO with occupancy count; pointers wrap modulo DEPTH (power of 2).
module byte_fifo #(
    parameter int unsigned DEPTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic                     pop_i,
    input  logic [7:0]               wdata_i,
    output logic [7:0]               rdata_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [7:0]    mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;
    logic          do_push, do_pop;

    always_comb begin
        full_o  = (count_q == (AW + 1)'(DEPTH));
        empty_o = (count_q == '0);
        do_push = push_i && !full_o;
        do_pop  = pop_i && !empty_o;
        rdata_o = mem_q[rd_ptr_q];
        count_o = count_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            unique case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Storage needs no reset; the pointers and count define validity.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= wdata_i;
    end

endmodule

// File: rtl/uart_apb_tx_bridge.sv
// Buffers a valid/ready byte stream and issues one APB write per byte to a fixed UART address.
module uart_apb_tx_bridge
    import uart_bridge_pkg::*;
#(
    parameter int unsigned APB_ADDR_WIDTH = 32,
    parameter int unsigned APB_DATA_WIDTH = 32,
    parameter int unsigned FIFO_DEPTH     = 16,
    parameter logic [APB_ADDR_WIDTH-1:0] TX_ADDR = APB_ADDR_WIDTH'(DEFAULT_TX_ADDR)
) (
    input  logic                          clk_i,
    input  logic                          rst_ni,
    input  logic [7:0]                    data_i,
    input  logic                          valid_i,
    output logic                          ready_o,
    output logic                          psel_o,
    output logic                          penable_o,
    output logic                          pwrite_o,
    output logic [APB_ADDR_WIDTH-1:0]     paddr_o,
    output logic [APB_DATA_WIDTH-1:0]     pwdata_o,
    input  logic                          pready_i,
    input  logic                          pslverr_i,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_o,
    output logic                          busy_o,
    output logic                          err_o,
    output logic [7:0]                    err_cnt_o,
    input  logic                          err_clr_i
);

    apb_state_e                state_q, state_d;
    logic [APB_DATA_WIDTH-1:0] pwdata_q, pwdata_d;
    logic                      err_q, err_d;
    logic [7:0]                err_cnt_q, err_cnt_d;
    logic                      running_q;
    logic                      fifo_push, fifo_pop, fifo_full, fifo_empty;
    logic [7:0]                fifo_rdata;
    logic                      slv_err;

    byte_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (data_i),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count_o)
    );

    // running_q keeps ready_o low while reset is held.
    assign ready_o   = running_q && !fifo_full;
    assign fifo_push = valid_i && ready_o;

    always_comb begin
        state_d  = state_q;
        pwdata_d = pwdata_q;
        fifo_pop = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    pwdata_d      = '0;
                    pwdata_d[7:0] = fifo_rdata;
                    state_d       = SETUP;
                end
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                // Errored bytes are popped too: no retry.
                if (pready_i) begin
                    fifo_pop = 1'b1;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        slv_err   = (state_q == ACCESS) && pready_i && pslverr_i;
        err_d     = err_q;
        err_cnt_d = err_cnt_q;
        if (slv_err) begin
            err_d = 1'b1;
            if (err_clr_i)               err_cnt_d = 8'd1;
            else if (err_cnt_q != 8'hff) err_cnt_d = err_cnt_q + 8'd1;
        end else if (err_clr_i) begin
            err_d     = 1'b0;
            err_cnt_d = 8'd0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            pwdata_q  <= '0;
            err_q     <= 1'b0;
            err_cnt_q <= 8'd0;
            running_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            pwdata_q  <= pwdata_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            running_q <= 1'b1;
        end
    end

    always_comb begin
        psel_o    = (state_q != IDLE);
        penable_o = (state_q == ACCESS);
        pwrite_o  = psel_o;
        paddr_o   = psel_o ? TX_ADDR : '0;
        pwdata_o  = pwdata_q;
        busy_o    = !fifo_empty || (state_q != IDLE);
        err_o     = err_q;
        err_cnt_o = err_cnt_q;
    end

endmodule

// File: tb/tb_uart_apb_tx_bridge.sv
// Directed bench for uart_apb_tx_bridge with a simple APB slave and write logger.
module tb_uart_apb_tx_bridge;

    localparam logic [31:0] TX = 32'h1000_0000;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [7:0]  data = 8'h00;
    logic        valid = 1'b0;
    logic        ready_o;
    logic        psel_o, penable_o, pwrite_o;
    logic [31:0] paddr_o, pwdata_o;
    logic        pready = 1'b1;
    logic        pslverr;
    logic [4:0]  fifo_count_o;
    logic        busy_o, err_o;
    logic [7:0]  err_cnt_o;
    logic        err_clr = 1'b0;

    logic        slv_err_en = 1'b0;
    logic [7:0]  err_byte = 8'h55;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // Slave model: signals an error when the chosen byte is written.
    assign pslverr = slv_err_en && psel_o && penable_o && (pwdata_o[7:0] == err_byte);

    uart_apb_tx_bridge #(
        .APB_ADDR_WIDTH (32),
        .APB_DATA_WIDTH (32),
        .FIFO_DEPTH     (16),
        .TX_ADDR        (TX)
    ) dut (
        .clk_i        (clk),
        .rst_ni       (rst_n),
        .data_i       (data),
        .valid_i      (valid),
        .ready_o      (ready_o),
        .psel_o       (psel_o),
        .penable_o    (penable_o),
        .pwrite_o     (pwrite_o),
        .paddr_o      (paddr_o),
        .pwdata_o     (pwdata_o),
        .pready_i     (pready),
        .pslverr_i    (pslverr),
        .fifo_count_o (fifo_count_o),
        .busy_o       (busy_o),
        .err_o        (err_o),
        .err_cnt_o    (err_cnt_o),
        .err_clr_i    (err_clr)
    );

    // Completed-transfer log and bus activity counters.
    logic [7:0] wr_q[$];
    logic       werr_q[$];
    int         psel_cycles = 0;
    int         b2b = 0;
    logic       last_done = 1'b0;

    always @(posedge clk) begin
        if (psel_o) psel_cycles <= psel_cycles + 1;
        if (last_done && psel_o) b2b <= b2b + 1;
        last_done <= rst_n && psel_o && penable_o && pready;
        if (psel_o && penable_o && pready) begin
            wr_q.push_back(pwdata_o[7:0]);
            werr_q.push_back(pslverr);
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running at 200000");
        $fatal(1, "timeout");
    end

    task automatic push_byte(input logic [7:0] b);
        int n = 0;
        @(negedge clk);
        while (!ready_o && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL push_ready: ready_o=%0b required 1", ready_o);
        end
        data  = b;
        valid = 1'b1;
        @(negedge clk);
        valid = 1'b0;
    endtask

    task automatic wait_idle(input int maxc);
        int n = 0;
        while (busy_o && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (busy_o !== 1'b0) begin
            errors++;
            $display("FAIL wait_idle: busy_o=%0b required 0 after %0d cycles", busy_o, n);
        end
    endtask

    task automatic wait_penable(input int maxc);
        int n = 0;
        while (penable_o !== 1'b1 && n < maxc) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (penable_o !== 1'b1) begin
            errors++;
            $display("FAIL wait_penable: penable_o=%0b required 1 after %0d cycles", penable_o, n);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ready_o, psel_o, penable_o, pwrite_o, busy_o, err_o} !== 6'b0) begin
            errors++;
            $display("FAIL reset_ctrl: rdy/psel/pen/pwr/busy/err=%b required 000000",
                     {ready_o, psel_o, penable_o, pwrite_o, busy_o, err_o});
        end
        checks++;
        if (paddr_o !== 32'h0 || pwdata_o !== 32'h0) begin
            errors++;
            $display("FAIL reset_bus: paddr=%h pwdata=%h required 0 0", paddr_o, pwdata_o);
        end
        checks++;
        if (fifo_count_o !== 5'd0 || err_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL reset_counts: count=%0d err_cnt=%0d required 0 0",
                     fifo_count_o, err_cnt_o);
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: ready_o=%0b required 1", ready_o);
        end
    endtask

    task automatic test_single;
        int base = wr_q.size();
        push_byte(8'h41);
        checks++;
        if (fifo_count_o !== 5'd1 || psel_o !== 1'b0 || busy_o !== 1'b1) begin
            errors++;
            $display("FAIL single_accept: count=%0d psel=%0b busy=%0b required 1 0 1",
                     fifo_count_o, psel_o, busy_o);
        end
        @(negedge clk);
        checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b0 || pwrite_o !== 1'b1) begin
            errors++;
            $display("FAIL single_setup: psel=%0b pen=%0b pwrite=%0b required 1 0 1",
                     psel_o, penable_o, pwrite_o);
        end
        checks++;
        if (paddr_o !== TX || pwdata_o !== 32'h41) begin
            errors++;
            $display("FAIL single_setup_bus: paddr=%h pwdata=%h required %h 00000041",
                     paddr_o, pwdata_o, TX);
        end
        @(negedge clk);
        checks++;
        if (psel_o !== 1'b1 || penable_o !== 1'b1) begin
            errors++;
            $display("FAIL single_access: psel=%0b pen=%0b required 1 1", psel_o, penable_o);
        end
        @(negedge clk);
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || fifo_count_o !== 5'd0 || busy_o !== 1'b0) begin
            errors++;
            $display("FAIL single_done: psel=%0b pen=%0b count=%0d busy=%0b required 0 0 0 0",
                     psel_o, penable_o, fifo_count_o, busy_o);
        end
        checks++;
        if (wr_q.size() - base !== 1 || wr_q[base] !== 8'h41) begin
            errors++;
            $display("FAIL single_log: writes=%0d first=%h required 1 41",
                     wr_q.size() - base, (wr_q.size() > base) ? wr_q[base] : 8'hxx);
        end
    endtask

    task automatic test_wait_states;
        int acc = 0;
        pready = 1'b0;
        push_byte(8'h5A);
        wait_penable(10);
        while (penable_o === 1'b1 && acc < 20) begin
            acc++;
            checks++;
            if (paddr_o !== TX || pwdata_o !== 32'h5A || psel_o !== 1'b1) begin
                errors++;
                $display("FAIL wait_stable: cycle %0d paddr=%h pwdata=%h psel=%0b required %h 5a 1",
                         acc, paddr_o, pwdata_o, psel_o, TX);
            end
            if (acc == 4) pready = 1'b1;
            @(negedge clk);
        end
        checks++;
        if (acc !== 4) begin
            errors++;
            $display("FAIL wait_access_len: access cycles=%0d required 4", acc);
        end
        checks++;
        if (fifo_count_o !== 5'd0) begin
            errors++;
            $display("FAIL wait_count: count=%0d required 0", fifo_count_o);
        end
        pready = 1'b1;
    endtask

    task automatic test_backpressure;
        int acc = 0;
        int base = wr_q.size();
        int b0;
        pready = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            data  = 8'(i);
            valid = 1'b1;
            if (ready_o) acc++;
        end
        @(negedge clk);
        valid = 1'b0;
        checks++;
        if (acc !== 16 || ready_o !== 1'b0 || fifo_count_o !== 5'd16) begin
            errors++;
            $display("FAIL bp_full: accepted=%0d ready=%0b count=%0d required 16 0 16",
                     acc, ready_o, fifo_count_o);
        end
        b0 = b2b;
        pready = 1'b1;
        wait_idle(200);
        checks++;
        if (wr_q.size() - base !== 16) begin
            errors++;
            $display("FAIL bp_num_writes: writes=%0d required 16", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 16; i++) begin
                checks++;
                if (wr_q[base + i] !== 8'(i)) begin
                    errors++;
                    $display("FAIL bp_order: write %0d = %h required %h", i, wr_q[base + i], 8'(i));
                end
            end
        end
        checks++;
        if (b2b - b0 !== 0) begin
            errors++;
            $display("FAIL bp_idle_gap: back-to-back transfers=%0d required 0", b2b - b0);
        end
    endtask

    task automatic test_error;
        int base = wr_q.size();
        slv_err_en = 1'b1;
        err_byte   = 8'h55;
        push_byte(8'h55);
        push_byte(8'h56);
        wait_idle(50);
        checks++;
        if (err_o !== 1'b1 || err_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL err_first: err=%0b cnt=%0d required 1 1", err_o, err_cnt_o);
        end
        checks++;
        if (wr_q.size() - base !== 2) begin
            errors++;
            $display("FAIL err_num_writes: writes=%0d required 2", wr_q.size() - base);
        end else begin
            checks++;
            if (wr_q[base] !== 8'h55 || werr_q[base] !== 1'b1 ||
                wr_q[base + 1] !== 8'h56 || werr_q[base + 1] !== 1'b0) begin
                errors++;
                $display("FAIL err_log: %h/%0b %h/%0b required 55/1 56/0",
                         wr_q[base], werr_q[base], wr_q[base + 1], werr_q[base + 1]);
            end
        end
        push_byte(8'h55);
        wait_penable(20);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_o !== 1'b1 || err_cnt_o !== 8'd1) begin
            errors++;
            $display("FAIL err_clr_collide: err=%0b cnt=%0d required 1 1", err_o, err_cnt_o);
        end
        wait_idle(20);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        checks++;
        if (err_o !== 1'b0 || err_cnt_o !== 8'd0) begin
            errors++;
            $display("FAIL err_clr_only: err=%0b cnt=%0d required 0 0", err_o, err_cnt_o);
        end
        slv_err_en = 1'b0;
    endtask

    task automatic test_reset_mid;
        int p0;
        pready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'h61 + 8'(i));
        wait_penable(10);
        checks++;
        if (fifo_count_o !== 5'd5) begin
            errors++;
            $display("FAIL rm_queued: count=%0d required 5", fifo_count_o);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (psel_o !== 1'b0 || penable_o !== 1'b0 || fifo_count_o !== 5'd0 || ready_o !== 1'b0) begin
            errors++;
            $display("FAIL rm_async: psel=%0b pen=%0b count=%0d ready=%0b required 0 0 0 0",
                     psel_o, penable_o, fifo_count_o, ready_o);
        end
        @(negedge clk);
        rst_n  = 1'b1;
        pready = 1'b1;
        p0     = psel_cycles;
        repeat (10) @(negedge clk);
        checks++;
        if (psel_cycles - p0 !== 0 || busy_o !== 1'b0 || fifo_count_o !== 5'd0) begin
            errors++;
            $display("FAIL rm_quiet: psel cycles=%0d busy=%0b count=%0d required 0 0 0",
                     psel_cycles - p0, busy_o, fifo_count_o);
        end
    endtask

    task automatic test_push_pop;
        int base = wr_q.size();
        pready = 1'b0;
        push_byte(8'hA0);
        push_byte(8'hA1);
        push_byte(8'hA2);
        wait_penable(10);
        checks++;
        if (fifo_count_o !== 5'd3) begin
            errors++;
            $display("FAIL pp_before: count=%0d required 3", fifo_count_o);
        end
        data   = 8'hA3;
        valid  = 1'b1;
        pready = 1'b1;
        @(negedge clk);
        valid  = 1'b0;
        pready = 1'b0;
        checks++;
        if (fifo_count_o !== 5'd3) begin
            errors++;
            $display("FAIL pp_count: count=%0d required 3", fifo_count_o);
        end
        pready = 1'b1;
        wait_idle(50);
        checks++;
        if (wr_q.size() - base !== 4) begin
            errors++;
            $display("FAIL pp_num_writes: writes=%0d required 4", wr_q.size() - base);
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (wr_q[base + i] !== 8'hA0 + 8'(i)) begin
                    errors++;
                    $display("FAIL pp_order: write %0d = %h required %h",
                             i, wr_q[base + i], 8'hA0 + 8'(i));
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_wait_states();
        test_backpressure();
        test_error();
        test_reset_mid();
        test_push_pop();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
